// File: rtl/uart_rx_oversample.sv
// rtl/uart_rx_oversample.sv - oversampling UART receiver with majority-vote bit decisions
//
// Ports:
//   clk        system clock
//   syncReset  synchronous reset, active high
//   en         sample tick at OVERSAMPLE x baud (pulse or held high)
//   rx         asynchronous serial input, idle high
//   data       last received word (held until the next done)
//   done       one-cycle strobe; data and err valid this cycle
//   err        framing or parity error of the frame flagged by done
//   busy       receiver is in any state other than IDLE
module uart_rx_oversample #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 syncReset,
  input  logic                 en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 done,
  output logic                 err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int M  = OVERSAMPLE / 2;

  localparam logic [TW-1:0] T_S0   = TW'(M - 1);
  localparam logic [TW-1:0] T_S1   = TW'(M);
  localparam logic [TW-1:0] T_DEC  = TW'(M + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BREAK  = 3'd5;

  logic                 rx_meta_q, rx_s_q;
  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 s0_q, s0_d, s1_q, s1_d;
  logic                 par_err_q, par_err_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic vote, decide, last, exp_par;

  // Third sample is the live synchronized value at the decision tick.
  assign vote    = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
  assign decide  = (tick_q == T_DEC);
  assign last    = (tick_q == T_LAST);
  assign exp_par = (^shift_q) ^ (PARITY_ODD != 0);

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    par_err_d = par_err_q;
    data_d    = data_q;
    err_d     = err_q;
    done_d    = 1'b0;

    if (en) begin
      if (state_q != IDLE && state_q != BREAK) begin
        if (tick_q == T_S0) s0_d = rx_s_q;
        if (tick_q == T_S1) s1_d = rx_s_q;
        tick_d = last ? '0 : tick_q + T_ONE;
      end

      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            // The tick that sees the falling edge is tick 0 of the start bit,
            // so counting resumes at 1 on the next tick.
            state_d   = START;
            tick_d    = T_ONE;
            par_err_d = 1'b0;
          end
        end
        START: begin
          if (decide && vote) begin
            state_d = IDLE;
            tick_d  = '0;
          end else if (last) begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
        DATA: begin
          if (decide) shift_d = {vote, shift_q[DATA_BITS-1:1]};
          if (last) begin
            if (bit_q == 4'(DATA_BITS - 1)) begin
              state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end
        PARITY: begin
          if (decide) par_err_d = vote ^ exp_par;
          if (last) state_d = STOP;
        end
        STOP: begin
          // Finish at the stop-bit centre so the next start edge is not missed.
          if (decide) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            err_d   = ~vote | par_err_q;
            state_d = vote ? IDLE : BREAK;
            tick_d  = '0;
          end
        end
        BREAK: begin
          // A held-low line must return high before another frame is accepted.
          if (rx_s_q) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          tick_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (syncReset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      par_err_q <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      par_err_q <= par_err_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign data = data_q;
  assign done = done_q;
  assign err  = err_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb/tb_uart_rx_oversample.sv - scoreboard bench for uart_rx_oversample
module tb_uart_rx_oversample;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       syncReset, en, rx, rx_p;
  logic [7:0] data, data_p;
  logic       done, err, busy, done_p, err_p, busy_p;

  always #5 clk = ~clk;

  uart_rx_oversample #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk(clk), .syncReset(syncReset), .en(en), .rx(rx),
    .data(data), .done(done), .err(err), .busy(busy)
  );

  uart_rx_oversample #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk(clk), .syncReset(syncReset), .en(en), .rx(rx_p),
    .data(data_p), .done(done_p), .err(err_p), .busy(busy_p)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int en_div   = 1;
  int en_cnt   = 0;
  int fall_cyc = 0;
  int done_cyc = -1;
  logic busy_at_done = 1'b1;
  logic [8:0] q_main[$];
  logic [8:0] q_par[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (en_cnt >= en_div - 1) en_cnt = 0;
    else en_cnt = en_cnt + 1;
    en = (en_cnt == 0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (done === 1'b1) begin
      done_cyc     = cyc;
      busy_at_done = busy;
      if (q_main.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        e = q_main.pop_front();
        chk("word", {23'd0, err, data}, {23'd0, e});
      end
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (done_p === 1'b1) begin
      if (q_par.size() == 0) begin
        chk("spurious_done_par", 32'd1, 32'd0);
      end else begin
        e = q_par.pop_front();
        chk("word_par", {23'd0, err_p, data_p}, {23'd0, e});
      end
    end
  end

  task automatic idle(input int n);
    rx   = 1'b1;
    rx_p = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame starting at a negedge. glitch_idx inverts one clk of
  // the line; rst_idx pulses syncReset for one clk (negative disables).
  task automatic send(input bit sel_p, input logic [7:0] d, input bit has_par,
                      input bit par_bit, input bit stop_bit, input int glitch_idx,
                      input int rst_idx, input bit push, input bit exp_err);
    logic [10:0] bits;
    int nb, bt, b;
    logic v;
    bits = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    if (has_par) begin
      bits[9]  = par_bit;
      bits[10] = stop_bit;
      nb = 11;
    end else begin
      bits[9] = stop_bit;
      nb = 10;
    end
    bt = OS * en_div;
    if (push) begin
      if (sel_p) q_par.push_back({exp_err, d});
      else q_main.push_back({exp_err, d});
    end
    fall_cyc = cyc;
    for (int j = 0; j < nb * bt; j++) begin
      b = j / bt;
      v = bits[b];
      if (j == glitch_idx) v = ~v;
      if (sel_p) rx_p = v;
      else rx = v;
      if (rst_idx >= 0 && j == rst_idx + 1) begin
        chk("rst_data", {24'd0, data}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err",  {31'd0, err},  32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
      end
      syncReset = (j == rst_idx);
      @(negedge clk);
    end
    syncReset = 1'b0;
  endtask

  initial begin
    int lat;
    rx = 1'b1;
    rx_p = 1'b1;
    syncReset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_data", {24'd0, data}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_err",  {31'd0, err},  32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    syncReset = 1'b0;
    idle(5);

    // Clean frame, latency and busy falling with done
    done_cyc = -1;
    send(0, 8'h55, 0, 0, 1, -1, -1, 1, 0);
    lat = done_cyc - fall_cyc;
    chk("t1_latency_in_window", {31'd0, (lat >= 154 && lat <= 156)}, 32'd1);
    chk("t1_busy_at_done", {31'd0, busy_at_done}, 32'd0);
    idle(20);

    // Framing error followed by a long break
    send(0, 8'hA3, 0, 0, 0, -1, -1, 1, 1);
    rx = 1'b0;
    repeat (40 * OS) @(negedge clk);
    chk("t2_busy_in_break", {31'd0, busy}, 32'd1);
    idle(5);
    chk("t2_busy_after_break", {31'd0, busy}, 32'd0);
    idle(10);

    // False start: 5-tick low pulse
    rx = 1'b0;
    repeat (4) @(negedge clk);
    chk("t3_busy_in_start", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rx = 1'b1;
    repeat (11) @(negedge clk);
    chk("t3_busy_after_false_start", {31'd0, busy}, 32'd0);
    idle(5);
    send(0, 8'h3C, 0, 0, 1, -1, -1, 1, 0);
    idle(20);

    // Even parity: good then bad parity bit
    send(1, 8'h07, 1, 1, 1, -1, -1, 1, 0);
    idle(20);
    send(1, 8'h07, 1, 0, 1, -1, -1, 1, 1);
    idle(20);

    // One-clk inversion at the centre sample of data bit 2
    send(0, 8'hF0, 0, 0, 1, 3 * OS + OS / 2, -1, 1, 0);
    idle(20);

    // en gated to one pulse per 7 clks
    en_div = 7;
    idle(14);
    send(0, 8'hF0, 0, 0, 1, -1, -1, 1, 0);
    idle(20 * 7);
    en_div = 1;
    idle(10);

    // Reset in the middle of data bit 4 aborts the frame
    send(0, 8'hF0, 0, 0, 1, -1, 5 * OS + OS / 2, 0, 0);
    idle(20);
    send(0, 8'h81, 0, 0, 1, -1, -1, 1, 0);
    idle(40);

    chk("drain_main", q_main.size(), 32'd0);
    chk("drain_par",  q_par.size(),  32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
